ll_req_arbiter: RTL and testbench

//  Shares the single ll_engine request interface (req_*/intf_ready/resp_gen_cmpltd) between two

---
 rtl/ll_req_arbiter_if.sv | 28 ++
 rtl/ll_req_arbiter.sv | 142 ++++++++++++++
 tb/tb_ll_req_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ll_req_arbiter_if.sv
// Engine-side request channel shared by the arbiter (master) and ll_engine (slave).
// Carries the captured request fields plus the engine's ready and completion strobes.
interface ll_req_arbiter_if #(
  parameter int HEADPTR_ADDR_WIDTH = 4,
  parameter int NODENUM_WIDTH      = 8,
  parameter int DATA_WIDTH         = 16,
  parameter int MAINOP_WIDTH       = 2,
  parameter int SPEC_WIDTH         = 2
) ();
  logic                          req_vld;
  logic [MAINOP_WIDTH-1:0]       req_main_op;
  logic [SPEC_WIDTH-1:0]         req_spec;
  logic [HEADPTR_ADDR_WIDTH-1:0] req_ll_num_in;
  logic [NODENUM_WIDTH-1:0]      req_pos;
  logic [DATA_WIDTH-1:0]         req_data;
  logic                          intf_ready;
  logic                          resp_gen_cmpltd;

  modport master (
    output req_vld, req_main_op, req_spec, req_ll_num_in, req_pos, req_data,
    input  intf_ready, resp_gen_cmpltd
  );

  modport slave (
    input  req_vld, req_main_op, req_spec, req_ll_num_in, req_pos, req_data,
    output intf_ready, resp_gen_cmpltd
  );
endinterface

// File: rtl/ll_req_arbiter.sv
// Two-port round-robin arbiter in front of the ll_engine request channel; the granted
// port owns the engine until completion or a WAIT_RESP timeout.
module ll_req_arbiter #(
  parameter int HEADPTR_ADDR_WIDTH = 4,
  parameter int NODENUM_WIDTH      = 8,
  parameter int DATA_WIDTH         = 16,
  parameter int MAINOP_WIDTH       = 2,
  parameter int SPEC_WIDTH         = 2,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [1:0]                      s_req_vld,
  input  logic [2*MAINOP_WIDTH-1:0]       s_main_op,
  input  logic [2*SPEC_WIDTH-1:0]         s_spec,
  input  logic [2*HEADPTR_ADDR_WIDTH-1:0] s_ll_num,
  input  logic [2*NODENUM_WIDTH-1:0]      s_pos,
  input  logic [2*DATA_WIDTH-1:0]         s_data,
  output logic [1:0]                      s_req_rdy,
  output logic [1:0]                      s_done,
  output logic [1:0]                      s_timeout,
  ll_req_arbiter_if.master                eng,
  output logic                            busy,
  output logic                            timeout_sticky
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t                        state_reg;
  logic                          last_grant_reg;
  logic                          owner_reg;
  logic [CNT_W-1:0]              cnt_reg;
  logic [1:0]                    done_reg;
  logic [1:0]                    timeout_reg;
  logic                          sticky_reg;
  logic                          req_vld_reg;
  logic [MAINOP_WIDTH-1:0]       main_op_reg;
  logic [SPEC_WIDTH-1:0]         spec_reg;
  logic [HEADPTR_ADDR_WIDTH-1:0] ll_num_reg;
  logic [NODENUM_WIDTH-1:0]      pos_reg;
  logic [DATA_WIDTH-1:0]         data_reg;

  logic [MAINOP_WIDTH-1:0]       main_op_arr [2];
  logic [SPEC_WIDTH-1:0]         spec_arr    [2];
  logic [HEADPTR_ADDR_WIDTH-1:0] ll_num_arr  [2];
  logic [NODENUM_WIDTH-1:0]      pos_arr     [2];
  logic [DATA_WIDTH-1:0]         data_arr    [2];

  logic [1:0] grant;
  logic       winner;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign main_op_arr[gi] = s_main_op[gi*MAINOP_WIDTH +: MAINOP_WIDTH];
      assign spec_arr[gi]    = s_spec[gi*SPEC_WIDTH +: SPEC_WIDTH];
      assign ll_num_arr[gi]  = s_ll_num[gi*HEADPTR_ADDR_WIDTH +: HEADPTR_ADDR_WIDTH];
      assign pos_arr[gi]     = s_pos[gi*NODENUM_WIDTH +: NODENUM_WIDTH];
      assign data_arr[gi]    = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // On a tie the port that did not win last time is served.
  always_comb begin
    grant    = 2'b00;
    grant[0] = s_req_vld[0] && (!s_req_vld[1] || last_grant_reg);
    grant[1] = s_req_vld[1] && (!s_req_vld[0] || !last_grant_reg);
    winner   = grant[1];
  end

  // Masked during reset so a requester never sees an accept that the reset discards.
  assign s_req_rdy = (state_reg == IDLE && reset_n) ? grant : 2'b00;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      cnt_reg        <= '0;
      done_reg       <= 2'b00;
      timeout_reg    <= 2'b00;
      sticky_reg     <= 1'b0;
      req_vld_reg    <= 1'b0;
      main_op_reg    <= '0;
      spec_reg       <= '0;
      ll_num_reg     <= '0;
      pos_reg        <= '0;
      data_reg       <= '0;
    end else begin
      done_reg    <= 2'b00;
      timeout_reg <= 2'b00;
      case (state_reg)
        IDLE: begin
          if (|s_req_vld) begin
            main_op_reg    <= main_op_arr[winner];
            spec_reg       <= spec_arr[winner];
            ll_num_reg     <= ll_num_arr[winner];
            pos_reg        <= pos_arr[winner];
            data_reg       <= data_arr[winner];
            owner_reg      <= winner;
            last_grant_reg <= winner;
            req_vld_reg    <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          if (eng.intf_ready) begin
            req_vld_reg <= 1'b0;
            cnt_reg     <= '0;
            state_reg   <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // Completion takes priority over a coincident terminal count.
          if (eng.resp_gen_cmpltd) begin
            done_reg  <= owner_reg ? 2'b10 : 2'b01;
            state_reg <= IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            timeout_reg <= owner_reg ? 2'b10 : 2'b01;
            sticky_reg  <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign eng.req_vld       = req_vld_reg;
  assign eng.req_main_op   = main_op_reg;
  assign eng.req_spec      = spec_reg;
  assign eng.req_ll_num_in = ll_num_reg;
  assign eng.req_pos       = pos_reg;
  assign eng.req_data      = data_reg;
  assign s_done            = done_reg;
  assign s_timeout         = timeout_reg;
  assign timeout_sticky    = sticky_reg;
  assign busy              = (state_reg != IDLE);
endmodule

// File: tb/tb_ll_req_arbiter.sv
// Directed bench for ll_req_arbiter with an 8-cycle timeout; inputs change 2 time units
// after each rising edge and outputs are checked there.
module tb_ll_req_arbiter;
  localparam int HW = 4, NW = 8, DW = 16, MW = 2, SW = 2, TO = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      s_req_vld;
  logic [2*MW-1:0] s_main_op;
  logic [2*SW-1:0] s_spec;
  logic [2*HW-1:0] s_ll_num;
  logic [2*NW-1:0] s_pos;
  logic [2*DW-1:0] s_data;
  logic [1:0]      s_req_rdy, s_done, s_timeout;
  logic            busy, timeout_sticky;

  int tests  = 0;
  int failed = 0;

  ll_req_arbiter_if #(.HEADPTR_ADDR_WIDTH(HW), .NODENUM_WIDTH(NW), .DATA_WIDTH(DW),
                      .MAINOP_WIDTH(MW), .SPEC_WIDTH(SW)) eng_if ();

  ll_req_arbiter #(.HEADPTR_ADDR_WIDTH(HW), .NODENUM_WIDTH(NW), .DATA_WIDTH(DW),
                   .MAINOP_WIDTH(MW), .SPEC_WIDTH(SW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .s_req_vld(s_req_vld), .s_main_op(s_main_op),
    .s_spec(s_spec), .s_ll_num(s_ll_num), .s_pos(s_pos), .s_data(s_data),
    .s_req_rdy(s_req_rdy), .s_done(s_done), .s_timeout(s_timeout), .eng(eng_if),
    .busy(busy), .timeout_sticky(timeout_sticky)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_rdy [4];
    exp_rdy[0] = 2'b10; exp_rdy[1] = 2'b01; exp_rdy[2] = 2'b10; exp_rdy[3] = 2'b01;

    reset_n = 1'b0; s_req_vld = 2'b00; s_main_op = '0; s_spec = '0; s_ll_num = '0;
    s_pos = '0; s_data = '0; eng_if.intf_ready = 1'b0; eng_if.resp_gen_cmpltd = 1'b0;
    step(); step();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_req_vld", 32'(eng_if.req_vld), 32'h0);
    check("rst_done", 32'(s_done), 32'h0);
    check("rst_timeout", 32'(s_timeout), 32'h0);
    check("rst_sticky", 32'(timeout_sticky), 32'h0);
    reset_n = 1'b1;

    // Port 0 alone: INSERT pos 3 data BEEF, completion 5 cycles after accept.
    s_req_vld = 2'b01; s_main_op = 4'b0001; s_spec = 4'b0010; s_ll_num = 8'h05;
    s_pos = 16'h0003; s_data = 32'h0000_BEEF; eng_if.intf_ready = 1'b1;
    #1 check("p0_rdy", 32'(s_req_rdy), 32'h1);
    step();
    s_req_vld = 2'b00;
    check("p0_req_vld", 32'(eng_if.req_vld), 32'h1);
    check("p0_main_op", 32'(eng_if.req_main_op), 32'h1);
    check("p0_spec", 32'(eng_if.req_spec), 32'h2);
    check("p0_ll_num", 32'(eng_if.req_ll_num_in), 32'h5);
    check("p0_pos", 32'(eng_if.req_pos), 32'h3);
    check("p0_data", 32'(eng_if.req_data), 32'hBEEF);
    check("p0_busy", 32'(busy), 32'h1);
    step();
    check("p0_vld_drop", 32'(eng_if.req_vld), 32'h0);
    step(); step(); step(); step();
    eng_if.resp_gen_cmpltd = 1'b1;
    step();
    eng_if.resp_gen_cmpltd = 1'b0;
    check("p0_done", 32'(s_done), 32'h1);
    check("p0_no_timeout", 32'(s_timeout), 32'h0);
    check("p0_idle", 32'(busy), 32'h0);
    step();
    check("p0_done_pulse", 32'(s_done), 32'h0);

    // Both ports valid continuously, immediate completion; port 0 won last.
    s_req_vld = 2'b11; s_data = 32'h2222_1111;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("rr_rdy%0d", k), 32'(s_req_rdy), 32'(exp_rdy[k]));
      step();
      check($sformatf("rr_data%0d", k), 32'(eng_if.req_data),
            exp_rdy[k][1] ? 32'h2222 : 32'h1111);
      check($sformatf("rr_rdy_issue%0d", k), 32'(s_req_rdy), 32'h0);
      step();
      eng_if.resp_gen_cmpltd = 1'b1;
      step();
      eng_if.resp_gen_cmpltd = 1'b0;
      check($sformatf("rr_done%0d", k), 32'(s_done), 32'(exp_rdy[k]));
    end

    // Engine back-pressure: port 1 granted, held in ISSUE for 20 cycles.
    s_req_vld = 2'b10; s_data = 32'h1234_0000; eng_if.intf_ready = 1'b0;
    #1 check("bp_rdy", 32'(s_req_rdy), 32'h2);
    step();
    s_req_vld = 2'b01; s_data = 32'hFFFF_0000;
    for (int k = 0; k < 20; k++) begin
      #1;
      check("bp_req_vld", 32'(eng_if.req_vld), 32'h1);
      check("bp_data", 32'(eng_if.req_data), 32'h1234);
      check("bp_rdy_none", 32'(s_req_rdy), 32'h0);
      check("bp_timeout", 32'(s_timeout), 32'h0);
      step();
    end
    s_req_vld = 2'b00; eng_if.intf_ready = 1'b1;
    step();
    eng_if.resp_gen_cmpltd = 1'b1;
    step();
    eng_if.resp_gen_cmpltd = 1'b0;
    check("bp_done", 32'(s_done), 32'h2);
    check("bp_sticky", 32'(timeout_sticky), 32'h0);

    // Timeout: port 0, no completion.
    s_req_vld = 2'b01;
    #1 check("to_rdy", 32'(s_req_rdy), 32'h1);
    step();
    s_req_vld = 2'b00;
    step();
    for (int k = 0; k < TO - 1; k++) begin
      step();
      check($sformatf("to_wait%0d", k), 32'(s_timeout), 32'h0);
    end
    step();
    check("to_pulse", 32'(s_timeout), 32'h1);
    check("to_sticky", 32'(timeout_sticky), 32'h1);
    check("to_no_done", 32'(s_done), 32'h0);
    check("to_idle", 32'(busy), 32'h0);
    step();
    check("to_pulse_end", 32'(s_timeout), 32'h0);
    check("to_sticky_hold", 32'(timeout_sticky), 32'h1);

    // Completion on the terminal count wins over timeout.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("rst2_sticky", 32'(timeout_sticky), 32'h0);
    s_req_vld = 2'b10;
    step();
    s_req_vld = 2'b00;
    step();
    for (int k = 0; k < TO - 1; k++) step();
    eng_if.resp_gen_cmpltd = 1'b1;
    step();
    eng_if.resp_gen_cmpltd = 1'b0;
    check("edge_done", 32'(s_done), 32'h2);
    check("edge_timeout", 32'(s_timeout), 32'h0);
    check("edge_sticky", 32'(timeout_sticky), 32'h0);

    // Reset in WAIT_RESP drops the op; tie afterwards goes to port 0.
    s_req_vld = 2'b01; s_data = 32'h0000_5A5A;
    step();
    s_req_vld = 2'b00;
    step(); step();
    reset_n = 1'b0; eng_if.resp_gen_cmpltd = 1'b1; s_req_vld = 2'b11;
    step();
    eng_if.resp_gen_cmpltd = 1'b0;
    check("wr_busy", 32'(busy), 32'h0);
    check("wr_req_vld", 32'(eng_if.req_vld), 32'h0);
    check("wr_data", 32'(eng_if.req_data), 32'h0);
    check("wr_done", 32'(s_done), 32'h0);
    check("wr_timeout", 32'(s_timeout), 32'h0);
    check("wr_rdy_in_reset", 32'(s_req_rdy), 32'h0);
    reset_n = 1'b1;
    #1 check("wr_tie_p0", 32'(s_req_rdy), 32'h1);
    step();
    check("wr_regrant", 32'(eng_if.req_vld), 32'h1);
    check("wr_regrant_data", 32'(eng_if.req_data), 32'h5A5A);
    check("wr_no_done", 32'(s_done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
